// File: rtl/pong_renderer.sv
// rtl/pong_renderer.sv - pong pixel generator: per-frame state snapshot, 2-stage hit/colour pipeline
module pong_renderer #(
    parameter logic [9:0] H_VIDEO      = 10'd640,
    parameter logic [9:0] V_VIDEO      = 10'd480,
    parameter logic [9:0] SQ_WIDTH     = 10'd16,
    parameter logic [9:0] PDL_WIDTH    = 10'd12,
    parameter logic [9:0] PDL_HEIGHT   = 10'd96,
    parameter logic [9:0] NET_X        = 10'd318,
    parameter int         BLINK_FRAMES = 30
) (
    input  logic       clk_0,
    input  logic       rst,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       video_on,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [9:0] sq_xpos,
    input  logic [9:0] sq_ypos,
    input  logic [9:0] pdl1_xpos,
    input  logic [9:0] pdl1_ypos,
    input  logic [9:0] pdl2_xpos,
    input  logic [9:0] pdl2_ypos,
    input  logic       sq_shown,
    input  logic [3:0] score_p1,
    input  logic [3:0] score_p2,
    input  logic       game_over,
    input  logic       game_startup,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       hsync_out,
    output logic       vsync_out
);
    localparam int         FW        = $clog2(BLINK_FRAMES);
    localparam logic [9:0] DIGIT_Y   = 10'd16;
    localparam logic [9:0] DIGIT_W   = 10'd20;
    localparam logic [9:0] DIGIT_H   = 10'd36;
    localparam logic [9:0] SEG_T     = 10'd4;
    localparam logic [9:0] P1_TENS_X = 10'd248;
    localparam logic [9:0] P1_UNIT_X = 10'd276;
    localparam logic [9:0] P2_TENS_X = 10'd344;
    localparam logic [9:0] P2_UNIT_X = 10'd372;

    logic [9:0]    s_sqx, s_sqy, s_p1x, s_p1y, s_p2x, s_p2y;
    logic          s_shown, s_go, s_start, blink;
    logic [3:0]    s_sc1, s_sc2;
    logic [FW-1:0] frame_cnt;
    logic          snap_evt;

    assign snap_evt = (pix_x == 10'd0) && (pix_y == V_VIDEO);

    // Blink only runs once a game-over frame has already been snapshotted, so a new run starts lit.
    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            s_sqx <= 10'd320; s_sqy <= 10'd240;
            s_p1x <= 10'd24;  s_p1y <= 10'd191;
            s_p2x <= 10'd603; s_p2y <= 10'd191;
            s_shown <= 1'b0; s_go <= 1'b0; s_start <= 1'b0;
            s_sc1 <= 4'd0; s_sc2 <= 4'd0;
            frame_cnt <= '0; blink <= 1'b1;
        end else if (snap_evt) begin
            s_sqx <= sq_xpos;   s_sqy <= sq_ypos;
            s_p1x <= pdl1_xpos; s_p1y <= pdl1_ypos;
            s_p2x <= pdl2_xpos; s_p2y <= pdl2_ypos;
            s_shown <= sq_shown; s_go <= game_over; s_start <= game_startup;
            s_sc1 <= score_p1; s_sc2 <= score_p2;
            if (!game_over || !s_go) begin
                frame_cnt <= '0;
                blink     <= 1'b1;
            end else if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt <= '0;
                blink     <= ~blink;
            end else begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    function automatic logic in_span(input logic [9:0] p, input logic [9:0] base, input logic [9:0] w);
        in_span = ({1'b0, p} >= {1'b0, base}) && ({1'b0, p} < ({1'b0, base} + {1'b0, w}));
    endfunction

    // Segment mask bits 6..0 = a (top), b, c, d (bottom), e, f, g (middle).
    function automatic logic glyph_hit(input logic [9:0] x, input logic [9:0] y,
                                       input logic [9:0] ox, input logic [3:0] d, input logic en);
        logic [9:0] u, v;
        logic [6:0] m;
        logic       in_box, upper, left, right;
        u      = x - ox;
        v      = y - DIGIT_Y;
        in_box = in_span(x, ox, DIGIT_W) && in_span(y, DIGIT_Y, DIGIT_H);
        upper  = v < (DIGIT_H >> 1);
        left   = u < SEG_T;
        right  = u >= (DIGIT_W - SEG_T);
        case (d)
            4'd0:    m = 7'h7E;
            4'd1:    m = 7'h30;
            4'd2:    m = 7'h6D;
            4'd3:    m = 7'h79;
            4'd4:    m = 7'h33;
            4'd5:    m = 7'h5B;
            4'd6:    m = 7'h5F;
            4'd7:    m = 7'h70;
            4'd8:    m = 7'h7F;
            4'd9:    m = 7'h7B;
            default: m = 7'h00;
        endcase
        glyph_hit = en && in_box &&
                    ((m[6] && v < SEG_T) ||
                     (m[5] && right && upper) ||
                     (m[4] && right && !upper) ||
                     (m[3] && v >= (DIGIT_H - SEG_T)) ||
                     (m[2] && left && !upper) ||
                     (m[1] && left && upper) ||
                     (m[0] && v >= ((DIGIT_H >> 1) - (SEG_T >> 1)) && v < ((DIGIT_H >> 1) + (SEG_T >> 1))));
    endfunction

    logic       hit_sq_c, hit_p1_c, hit_p2_c, hit_net_c, hit_digit_c, vid_c;
    logic [3:0] unit1, unit2;

    always_comb begin
        unit1 = 4'd0;
        unit2 = 4'd0;
        if (!s_start) begin
            unit1 = (s_sc1 >= 4'd10) ? s_sc1 - 4'd10 : s_sc1;
            unit2 = (s_sc2 >= 4'd10) ? s_sc2 - 4'd10 : s_sc2;
        end
        vid_c       = video_on && (pix_x < H_VIDEO) && (pix_y < V_VIDEO);
        hit_sq_c    = in_span(pix_x, s_sqx, SQ_WIDTH) && in_span(pix_y, s_sqy, SQ_WIDTH);
        hit_p1_c    = in_span(pix_x, s_p1x, PDL_WIDTH) && in_span(pix_y, s_p1y, PDL_HEIGHT);
        hit_p2_c    = in_span(pix_x, s_p2x, PDL_WIDTH) && in_span(pix_y, s_p2y, PDL_HEIGHT);
        hit_net_c   = in_span(pix_x, NET_X, 10'd4) && !pix_y[4] && !s_start && !s_go;
        hit_digit_c = glyph_hit(pix_x, pix_y, P1_TENS_X, 4'd1, (s_sc1 >= 4'd10) && !s_start) ||
                      glyph_hit(pix_x, pix_y, P1_UNIT_X, unit1, 1'b1) ||
                      glyph_hit(pix_x, pix_y, P2_TENS_X, 4'd1, (s_sc2 >= 4'd10) && !s_start) ||
                      glyph_hit(pix_x, pix_y, P2_UNIT_X, unit2, 1'b1);
    end

    logic        hit_sq, hit_p1, hit_p2, hit_net, hit_digit, vid_s1;
    logic        hs_d1, vs_d1;
    logic [11:0] rgb;

    always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
            hit_sq <= 1'b0; hit_p1 <= 1'b0; hit_p2 <= 1'b0;
            hit_net <= 1'b0; hit_digit <= 1'b0; vid_s1 <= 1'b0;
            hs_d1 <= 1'b0; vs_d1 <= 1'b0;
            hsync_out <= 1'b0; vsync_out <= 1'b0;
            rgb <= 12'h000;
        end else begin
            hit_sq <= hit_sq_c; hit_p1 <= hit_p1_c; hit_p2 <= hit_p2_c;
            hit_net <= hit_net_c; hit_digit <= hit_digit_c; vid_s1 <= vid_c;
            hs_d1 <= hsync_in; vs_d1 <= vsync_in;
            hsync_out <= hs_d1; vsync_out <= vs_d1;
            if (!vid_s1)
                rgb <= 12'h000;
            else if (hit_sq && s_shown && !s_start)
                rgb <= 12'hFFF;
            else if (hit_p1 || hit_p2)
                rgb <= 12'hFFF;
            else if (hit_digit)
                rgb <= !s_go ? 12'hFFF : (blink ? 12'hF00 : 12'h000);
            else if (hit_net)
                rgb <= 12'h888;
            else
                rgb <= 12'h000;
        end
    end

    assign vga_r = rgb[11:8];
    assign vga_g = rgb[7:4];
    assign vga_b = rgb[3:0];
endmodule

// File: tb/tb_pong_renderer.sv
// tb/tb_pong_renderer.sv - randomized and directed self-checking bench for pong_renderer
module tb_pong_renderer;
    logic       clk_0 = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] pix_x = 10'd1, pix_y = 10'd481;
    logic       video_on = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic [9:0] sq_xpos = 10'd320, sq_ypos = 10'd240;
    logic [9:0] pdl1_xpos = 10'd24, pdl1_ypos = 10'd191;
    logic [9:0] pdl2_xpos = 10'd603, pdl2_ypos = 10'd191;
    logic       sq_shown = 1'b0, game_over = 1'b0, game_startup = 1'b0;
    logic [3:0] score_p1 = 4'd0, score_p2 = 4'd0;
    logic [3:0] vga_r, vga_g, vga_b;
    logic       hsync_out, vsync_out;

    int checks = 0;
    int failures = 0;

    // Model of the frame snapshot the DUT should currently be drawing from.
    int m_sqx, m_sqy, m_p1x, m_p1y, m_p2x, m_p2y, m_sc1, m_sc2, m_run;
    bit m_shown, m_go, m_start;

    pong_renderer dut (
        .clk_0(clk_0), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .sq_xpos(sq_xpos), .sq_ypos(sq_ypos), .pdl1_xpos(pdl1_xpos), .pdl1_ypos(pdl1_ypos),
        .pdl2_xpos(pdl2_xpos), .pdl2_ypos(pdl2_ypos), .sq_shown(sq_shown),
        .score_p1(score_p1), .score_p2(score_p2), .game_over(game_over),
        .game_startup(game_startup),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #20 clk_0 = ~clk_0;

    initial begin
        #20ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic void model_reset();
        m_sqx = 320; m_sqy = 240; m_p1x = 24; m_p1y = 191; m_p2x = 603; m_p2y = 191;
        m_shown = 0; m_sc1 = 0; m_sc2 = 0; m_go = 0; m_start = 0; m_run = 0;
    endfunction

    function automatic bit in_rect(int x, int y, int x0, int y0, int w, int h);
        return x >= x0 && x < x0 + w && y >= y0 && y < y0 + h;
    endfunction

    // Seven segments a..g as inclusive rectangles inside a 20x36 box.
    function automatic bit glyph_on(int x, int y, int ox, int d);
        int masks [10] = '{'h7E, 'h30, 'h6D, 'h79, 'h33, 'h5B, 'h5F, 'h70, 'h7F, 'h7B};
        int sx0 [7] = '{0, 16, 16, 0, 0, 0, 0};
        int sx1 [7] = '{19, 19, 19, 19, 3, 3, 19};
        int sy0 [7] = '{0, 0, 18, 32, 18, 0, 16};
        int sy1 [7] = '{3, 17, 35, 35, 35, 17, 19};
        int u = x - ox;
        int v = y - 16;
        bit on = 0;
        for (int s = 0; s < 7; s++)
            if (((masks[d] >> (6 - s)) & 1) == 1 && u >= sx0[s] && u <= sx1[s] && v >= sy0[s] && v <= sy1[s])
                on = 1;
        return on;
    endfunction

    function automatic bit model_digit(int x, int y);
        bit hit = 0;
        if (!m_start && m_sc1 >= 10 && glyph_on(x, y, 248, 1)) hit = 1;
        if (!m_start && m_sc2 >= 10 && glyph_on(x, y, 344, 1)) hit = 1;
        if (glyph_on(x, y, 276, m_start ? 0 : m_sc1 % 10)) hit = 1;
        if (glyph_on(x, y, 372, m_start ? 0 : m_sc2 % 10)) hit = 1;
        return hit;
    endfunction

    function automatic logic [11:0] model_rgb(int x, int y, bit vo);
        bit blink_now = ((m_run - 1) / 30) % 2 == 0;
        if (!vo) return 12'h000;
        if (m_shown && !m_start && in_rect(x, y, m_sqx, m_sqy, 16, 16)) return 12'hFFF;
        if (in_rect(x, y, m_p1x, m_p1y, 12, 96) || in_rect(x, y, m_p2x, m_p2y, 12, 96)) return 12'hFFF;
        if (model_digit(x, y)) return !m_go ? 12'hFFF : (blink_now ? 12'hF00 : 12'h000);
        if (!m_go && !m_start && x >= 318 && x < 322 && (y / 16) % 2 == 0) return 12'h888;
        return 12'h000;
    endfunction

    task automatic snapshot();
        pix_x = 10'd0; pix_y = 10'd480; video_on = 1'b0;
        @(posedge clk_0); #1;
        pix_x = 10'd1; pix_y = 10'd481;
        m_sqx = sq_xpos; m_sqy = sq_ypos; m_p1x = pdl1_xpos; m_p1y = pdl1_ypos;
        m_p2x = pdl2_xpos; m_p2y = pdl2_ypos; m_shown = sq_shown;
        m_sc1 = score_p1; m_sc2 = score_p2; m_start = game_startup;
        m_go = game_over;
        m_run = game_over ? m_run + 1 : 0;
    endtask

    task automatic probe(input int x, input int y, input bit vo, input logic [11:0] exp, input string name);
        pix_x = 10'(x); pix_y = 10'(y); video_on = vo;
        @(posedge clk_0); @(posedge clk_0); #1;
        checks++;
        if ({vga_r, vga_g, vga_b} !== exp) begin
            failures++;
            $display("FAIL %s pixel (%0d,%0d) rgb=%h expected=%h", name, x, y, {vga_r, vga_g, vga_b}, exp);
        end
    endtask

    task automatic check_sync(input logic hs_exp, input logic vs_exp, input string name);
        checks++;
        if (hsync_out !== hs_exp || vsync_out !== vs_exp) begin
            failures++;
            $display("FAIL %s hsync/vsync=%b%b expected=%b%b", name, hsync_out, vsync_out, hs_exp, vs_exp);
        end
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk_0);
        #1;
        checks++;
        if ({vga_r, vga_g, vga_b} !== 12'h000) begin
            failures++;
            $display("FAIL reset_rgb rgb=%h expected=000", {vga_r, vga_g, vga_b});
        end
        check_sync(1'b0, 1'b0, "reset_sync");
        #5 rst = 1'b1;
        @(posedge clk_0); #1;
    endtask

    task automatic test_square();
        sq_xpos = 10'd100; sq_ypos = 10'd50; sq_shown = 1'b1;
        snapshot();
        probe(100, 50, 1, 12'hFFF, "sq_topleft");
        probe(116, 50, 1, 12'h000, "sq_right_edge");
        probe(99, 50, 1, 12'h000, "sq_left_edge");
        probe(115, 65, 1, 12'hFFF, "sq_bottomright");
        probe(100, 66, 1, 12'h000, "sq_bottom_edge");
    endtask

    task automatic test_snapshot_hold();
        sq_xpos = 10'd200;
        probe(100, 60, 1, 12'hFFF, "hold_old_pos");
        probe(200, 60, 1, 12'h000, "hold_new_pos_early");
        snapshot();
        probe(200, 60, 1, 12'hFFF, "new_pos_after_snap");
        probe(100, 60, 1, 12'h000, "old_pos_after_snap");
    endtask

    task automatic test_scores();
        score_p1 = 4'd10; score_p2 = 4'd7;
        snapshot();
        probe(264, 20, 1, 12'hFFF, "p1_tens_right_top");
        probe(267, 40, 1, 12'hFFF, "p1_tens_right_bot");
        probe(263, 16, 1, 12'h000, "p1_tens_no_top_seg");
        probe(276, 16, 1, 12'hFFF, "p1_units_zero");
        probe(286, 34, 1, 12'h000, "p1_units_zero_no_mid");
        probe(344, 16, 1, 12'h000, "p2_tens_blank_a");
        probe(362, 30, 1, 12'h000, "p2_tens_blank_b");
        probe(372, 16, 1, 12'hFFF, "p2_units_seven");
        probe(318, 0, 1, 12'h888, "net_dash");
        probe(321, 15, 1, 12'h888, "net_dash_corner");
        probe(322, 0, 1, 12'h000, "net_right_edge");
        probe(318, 16, 1, 12'h000, "net_gap");
    endtask

    task automatic test_blink();
        score_p1 = 4'd8; game_over = 1'b1;
        for (int n = 1; n <= 120; n++) begin
            snapshot();
            probe(276, 16, 1, (((n - 1) / 30) % 2 == 0) ? 12'hF00 : 12'h000, $sformatf("blink_frame%0d", n));
            if (n % 10 == 1) probe(318, 0, 1, 12'h000, "net_off_game_over");
        end
        game_over = 1'b0;
        snapshot();
        probe(276, 16, 1, 12'hFFF, "digit_white_after_go");
        probe(318, 32, 1, 12'h888, "net_back_after_go");
    endtask

    task automatic test_sync_delay();
        hsync_in = 1'b1; vsync_in = 1'b0;
        @(posedge clk_0); #1;
        hsync_in = 1'b0; vsync_in = 1'b1;
        check_sync(1'b0, 1'b0, "sync_d1");
        @(posedge clk_0); #1;
        vsync_in = 1'b0;
        check_sync(1'b1, 1'b0, "sync_d2");
        @(posedge clk_0); #1;
        check_sync(1'b0, 1'b1, "sync_d3");
        @(posedge clk_0); #1;
        check_sync(1'b0, 1'b0, "sync_d4");
        probe(205, 60, 0, 12'h000, "blanked_square");
    endtask

    task automatic test_midframe_reset();
        pix_x = 10'd205; pix_y = 10'd60; video_on = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
        repeat (3) @(posedge clk_0);
        #5 rst = 1'b0;
        #1;
        checks++;
        if ({vga_r, vga_g, vga_b, hsync_out, vsync_out} !== 14'h0) begin
            failures++;
            $display("FAIL midreset_async rgb=%h syncs=%b%b expected all 0", {vga_r, vga_g, vga_b}, hsync_out, vsync_out);
        end
        @(posedge clk_0); #1;
        check_sync(1'b0, 1'b0, "midreset_sync_edge");
        hsync_in = 1'b0; vsync_in = 1'b0;
        model_reset();
        #5 rst = 1'b1;
        @(posedge clk_0); #1;
        probe(24, 191, 1, 12'hFFF, "rst_pdl1_tl");
        probe(35, 286, 1, 12'hFFF, "rst_pdl1_br");
        probe(36, 191, 1, 12'h000, "rst_pdl1_edge");
        probe(603, 191, 1, 12'hFFF, "rst_pdl2_tl");
        probe(614, 287, 1, 12'h000, "rst_pdl2_bottom_edge");
        probe(205, 60, 1, 12'h000, "rst_square_cleared");
        probe(320, 240, 1, 12'h000, "rst_square_hidden");
    endtask

    task automatic test_random();
        for (int it = 0; it < 16; it++) begin
            sq_xpos = 10'($urandom_range(0, 623)); sq_ypos = 10'($urandom_range(0, 463));
            pdl1_xpos = 10'($urandom_range(0, 627)); pdl1_ypos = 10'($urandom_range(0, 383));
            pdl2_xpos = 10'($urandom_range(0, 627)); pdl2_ypos = 10'($urandom_range(0, 383));
            sq_shown = 1'($urandom_range(0, 1));
            score_p1 = 4'($urandom_range(0, 15)); score_p2 = 4'($urandom_range(0, 15));
            game_startup = ($urandom_range(0, 3) == 0);
            game_over = ($urandom_range(0, 3) == 0);
            snapshot();
            for (int k = 0; k < 24; k++) begin
                int x, y, sel;
                sel = $urandom_range(0, 3);
                case (sel)
                    0: begin x = m_sqx + $urandom_range(0, 17) - 1; y = m_sqy + $urandom_range(0, 17) - 1; end
                    1: begin x = m_p1x + $urandom_range(0, 13) - 1; y = m_p1y + $urandom_range(0, 97) - 1; end
                    2: begin x = 244 + $urandom_range(0, 152); y = 14 + $urandom_range(0, 40); end
                    default: begin x = $urandom_range(0, 639); y = $urandom_range(0, 479); end
                endcase
                if (x < 0) x = 0;
                if (y < 0) y = 0;
                if (x > 639) x = 639;
                if (y > 479) y = 479;
                probe(x, y, 1, model_rgb(x, y, 1), "random");
            end
        end
    endtask

    initial begin
        test_reset();
        test_square();
        test_snapshot_hold();
        test_scores();
        test_blink();
        test_sync_delay();
        test_midframe_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
